// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV64-subset controller: FSM states,
// instruction classes, opcode constants, ALU op codes and operand-B selects.
package ctrl_pkg;

    localparam int unsigned OPW  = 4;
    localparam int unsigned SELW = 2;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_SD,
        CLS_BEQ,
        CLS_BNE
    } instr_cls_e;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [OPW-1:0] ALU_AND = 4'b0000;
    localparam logic [OPW-1:0] ALU_OR  = 4'b0001;
    localparam logic [OPW-1:0] ALU_ADD = 4'b0010;
    localparam logic [OPW-1:0] ALU_SUB = 4'b0110;
    // Reserved: the decoder never produces NOR.
    localparam logic [OPW-1:0] ALU_NOR = 4'b1100;

    localparam logic [SELW-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SELW-1:0] SRCB_FOUR = 2'b01;
    localparam logic [SELW-1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of {opcode, funct3, funct7_b5} into ALU op code,
// instruction class and an illegal flag.
// Optional feature: BNE_SUPPORT_EN decodes branch funct3=001 as BNE.
module alu_op_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]     opcode_i,
    input  logic [2:0]     funct3_i,
    input  logic           funct7_b5_i,
    output logic [OPW-1:0] alu_op_o,
    output instr_cls_e     cls_o,
    output logic           illegal_o
);

    // Opcode/funct lookup; anything not matched is flagged illegal.
    always_comb begin
        alu_op_o  = ALU_ADD;
        cls_o     = CLS_R;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_R, OP_I: begin
                cls_o = (opcode_i == OP_R) ? CLS_R : CLS_I;
                case (funct3_i)
                    3'b000:  alu_op_o = (opcode_i == OP_R && funct7_b5_i) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op_o = ALU_AND;
                    3'b110:  alu_op_o = ALU_OR;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_LD: cls_o = CLS_LD;
            OP_SD: cls_o = CLS_SD;
            OP_BR: begin
                alu_op_o = ALU_SUB;
                cls_o    = CLS_BEQ;
                case (funct3_i)
                    3'b000:  cls_o = CLS_BEQ;
`ifdef BNE_SUPPORT_EN
                    3'b001:  cls_o = CLS_BNE;
`endif
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_64.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) for the 64-bit ALU
// datapath; drives datapath enables, ALU op code and the memory handshake.
// Optional feature: BNE_SUPPORT_EN adds BNE (branch funct3=001).
module mc_control_64
    import ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_b5,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_src_a,
    output logic [SELW-1:0]  alu_src_b,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal
);

    state_e         state_q,  state_d;
    instr_cls_e     cls_q,    cls_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;

    logic [OPW-1:0] dec_op;
    instr_cls_e     dec_cls;
    logic           dec_illegal;

    alu_op_decode u_decode (
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .funct7_b5_i (funct7_b5),
        .alu_op_o    (dec_op),
        .cls_o       (dec_cls),
        .illegal_o   (dec_illegal)
    );

    // State, latched instruction class and latched ALU op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            cls_q    <= CLS_R;
            alu_op_q <= ALU_ADD;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            alu_op_q <= alu_op_d;
        end
    end

    // Next-state and control decode; outputs forced low while in reset so a
    // pending memory request is dropped at once.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        alu_op_d   = alu_op_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RS2;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    alu_op_d = dec_op;
                    cls_d    = dec_cls;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (cls_q)
                    CLS_R: begin
                        alu_src_b = SRCB_RS2;
                        state_d   = S_WB;
                    end
                    CLS_I: begin
                        alu_src_b = SRCB_IMM;
                        state_d   = S_WB;
                    end
                    CLS_LD, CLS_SD: begin
                        alu_src_b = SRCB_IMM;
                        state_d   = S_MEM;
                    end
                    CLS_BEQ: begin
                        pc_write = alu_zero;
                        pc_src   = 1'b1;
                        state_d  = S_FETCH;
                    end
`ifdef BNE_SUPPORT_EN
                    CLS_BNE: begin
                        pc_write = ~alu_zero;
                        pc_src   = 1'b1;
                        state_d  = S_FETCH;
                    end
`endif
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (cls_q == CLS_SD);
                if (mem_ready) begin
                    state_d = (cls_q == CLS_SD) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == CLS_LD);
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // FETCH always computes PC+4; other states present the latched op.
        alu_op = (state_q == S_FETCH) ? ALU_ADD : alu_op_q;

        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_RS2;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            illegal    = 1'b0;
            alu_op     = ALU_ADD;
        end
    end

endmodule

// File: tb/tb_mc_control_64.sv
// Directed bench for mc_control_64. Observed vector is
// {alu_op[3:0], mem_req, mem_we, iord, ir_write, pc_write, pc_src,
//  alu_src_a, alu_src_b[1:0], reg_write, mem_to_reg, illegal}.
module tb_mc_control_64;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write, mem_to_reg, illegal;

    logic [15:0] obs;
    int n_assert = 0;
    int n_fail   = 0;

    mc_control_64 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_b5  (funct7_b5),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal)
    );

    assign obs = {alu_op, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, reg_write, mem_to_reg, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive cycle inputs just after the edge, check at the falling edge.
    task automatic step(input logic rdy, input logic zero, input string tag,
                        input logic [15:0] exp);
        mem_ready = rdy;
        alu_zero  = zero;
        #4;
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic b5);
        opcode    = op;
        funct3    = f3;
        funct7_b5 = b5;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        alu_zero = 1'b0;
        set_instr(7'b0000000, 3'b000, 1'b0);
        #3;
        chk("reset_state", 16'h2000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // R-type SUB; mem_ready high outside FETCH/MEM must be ignored
        set_instr(7'b0110011, 3'b000, 1'b1);
        step(1'b1, 1'b0, "sub_fetch",  16'h2988);
        step(1'b1, 1'b0, "sub_decode", 16'h2000);
        step(1'b1, 1'b0, "sub_exec",   16'h6020);
        step(1'b1, 1'b0, "sub_wb",     16'h6004);
        step(1'b0, 1'b0, "sub_after",  16'h2808);

        // ORI with bit30 set: no SUBI, OR selected
        set_instr(7'b0010011, 3'b110, 1'b1);
        step(1'b1, 1'b0, "ori_fetch",  16'h2988);
        step(1'b0, 1'b0, "ori_decode", 16'h6000);
        step(1'b0, 1'b0, "ori_exec",   16'h1030);
        step(1'b0, 1'b0, "ori_wb",     16'h1004);

        // LD with 3 wait cycles in MEM: 8 cycles total
        set_instr(7'b0000011, 3'b011, 1'b0);
        step(1'b1, 1'b0, "ld_fetch",   16'h2988);
        step(1'b0, 1'b0, "ld_decode",  16'h1000);
        step(1'b0, 1'b0, "ld_exec",    16'h2030);
        step(1'b0, 1'b0, "ld_mem_w1",  16'h2A00);
        step(1'b0, 1'b0, "ld_mem_w2",  16'h2A00);
        step(1'b0, 1'b0, "ld_mem_w3",  16'h2A00);
        step(1'b1, 1'b0, "ld_mem_rdy", 16'h2A00);
        step(1'b0, 1'b0, "ld_wb",      16'h2006);

        // SD: straight back to FETCH after MEM
        set_instr(7'b0100011, 3'b011, 1'b0);
        step(1'b1, 1'b0, "sd_fetch",   16'h2988);
        step(1'b0, 1'b0, "sd_decode",  16'h2000);
        step(1'b0, 1'b0, "sd_exec",    16'h2030);
        step(1'b1, 1'b0, "sd_mem",     16'h2E00);
        step(1'b0, 1'b0, "sd_after",   16'h2808);

        // BEQ taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        step(1'b1, 1'b0, "beq1_fetch",  16'h2988);
        step(1'b0, 1'b0, "beq1_decode", 16'h2000);
        step(1'b0, 1'b1, "beq1_exec",   16'h60E0);
        // BEQ not taken; its FETCH is cycle 4 of the previous branch
        step(1'b1, 1'b0, "beq0_fetch",  16'h2988);
        step(1'b0, 1'b0, "beq0_decode", 16'h6000);
        step(1'b0, 1'b0, "beq0_exec",   16'h6060);

        // Unsupported opcode
        set_instr(7'b1111111, 3'b000, 1'b0);
        step(1'b1, 1'b0, "ill_fetch",  16'h2988);
        step(1'b1, 1'b0, "ill_decode", 16'h6001);
        step(1'b0, 1'b0, "ill_after",  16'h2808);

        // R-type with unsupported funct3=100
        set_instr(7'b0110011, 3'b100, 1'b0);
        step(1'b1, 1'b0, "rf3_fetch",  16'h2988);
        step(1'b0, 1'b0, "rf3_decode", 16'h6001);

        // Branch funct3=001
        set_instr(7'b1100011, 3'b001, 1'b0);
        step(1'b1, 1'b0, "bne_fetch",  16'h2988);
`ifdef BNE_SUPPORT_EN
        step(1'b0, 1'b0, "bne_decode", 16'h6000);
        step(1'b0, 1'b0, "bne_exec",   16'h60E0);
`else
        step(1'b0, 1'b0, "bne_decode", 16'h6001);
        step(1'b0, 1'b0, "bne_after",  16'h2808);
`endif

        // Reset asserted mid-MEM drops mem_req immediately
        set_instr(7'b0000011, 3'b011, 1'b0);
        step(1'b1, 1'b0, "rld_fetch",  16'h2988);
        step(1'b0, 1'b0, "rld_decode", 16'h6000);
        step(1'b0, 1'b0, "rld_exec",   16'h2030);
        step(1'b0, 1'b0, "rld_mem",    16'h2A00);
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #2;
        chk("rst_mid_mem", 16'h2000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, "rst_fetch", 16'h2808);
        set_instr(7'b0110011, 3'b111, 1'b0);
        step(1'b1, 1'b0, "and_fetch",  16'h2988);
        step(1'b0, 1'b0, "and_decode", 16'h2000);
        step(1'b0, 1'b0, "and_exec",   16'h0020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
